// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - operand/result queues around a single-job compute-unit launcher
module job_dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    input  logic        done,
    input  logic [15:0] res_in,
    output logic        start,
    output logic [7:0]  x_out,
    output logic [15:0] rd_data,
    output logic        op_full,
    output logic        res_empty,
    output logic        busy,
    output logic        err,
    output logic        wr_drop
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] BUSY_TIMEOUT = 8'd3;
    localparam logic [7:0] DONE_TIMEOUT = 8'd254;

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        err_q, wr_drop_q;

    logic [7:0]  op_mem_q [4];
    logic [1:0]  op_wr_ptr_q, op_rd_ptr_q;
    logic [2:0]  op_cnt_q, op_cnt_d;

    logic [15:0] res_mem_q [4];
    logic [1:0]  res_wr_ptr_q, res_rd_ptr_q;
    logic [2:0]  res_cnt_q, res_cnt_d;

    logic        op_push, op_pop, res_push, res_pop, err_set;

    assign op_push = wr_en && (op_cnt_q != 3'd4);
    assign res_pop = rd_en && (res_cnt_q != 3'd0);

    // Only the FSM pops operands, and only while a job owns the head entry.
    always_comb begin
        state_d  = state_q;
        op_pop   = 1'b0;
        res_push = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((op_cnt_q != 3'd0) && (res_cnt_q != 3'd4) && done)
                    state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!done) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == BUSY_TIMEOUT) begin
                    err_set = 1'b1;
                    op_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    res_push = 1'b1;
                    op_pop   = 1'b1;
                    state_d  = S_IDLE;
                end else if (timer_q == DONE_TIMEOUT) begin
                    err_set = 1'b1;
                    op_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = 8'd0;
        else if (timer_q != 8'hFF)
            timer_d = timer_q + 8'd1;
    end

    always_comb begin
        op_cnt_d = op_cnt_q;
        case ({op_push, op_pop})
            2'b10:   op_cnt_d = op_cnt_q + 3'd1;
            2'b01:   op_cnt_d = op_cnt_q - 3'd1;
            default: op_cnt_d = op_cnt_q;
        endcase
    end

    always_comb begin
        res_cnt_d = res_cnt_q;
        case ({res_push, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + 3'd1;
            2'b01:   res_cnt_d = res_cnt_q - 3'd1;
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 8'd0;
            err_q     <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            err_q     <= err_q | err_set;
            wr_drop_q <= wr_en && (op_cnt_q == 3'd4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) op_mem_q[i] <= 8'd0;
            op_wr_ptr_q <= 2'd0;
            op_rd_ptr_q <= 2'd0;
            op_cnt_q    <= 3'd0;
        end else begin
            if (op_push) begin
                op_mem_q[op_wr_ptr_q] <= wr_data;
                op_wr_ptr_q           <= op_wr_ptr_q + 2'd1;
            end
            if (op_pop)
                op_rd_ptr_q <= op_rd_ptr_q + 2'd1;
            op_cnt_q <= op_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) res_mem_q[i] <= 16'd0;
            res_wr_ptr_q <= 2'd0;
            res_rd_ptr_q <= 2'd0;
            res_cnt_q    <= 3'd0;
        end else begin
            if (res_push) begin
                res_mem_q[res_wr_ptr_q] <= res_in;
                res_wr_ptr_q            <= res_wr_ptr_q + 2'd1;
            end
            if (res_pop)
                res_rd_ptr_q <= res_rd_ptr_q + 2'd1;
            res_cnt_q <= res_cnt_d;
        end
    end

    // x_out tracks the head while a job is in flight; pushes only touch the tail.
    assign start     = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign x_out     = busy ? op_mem_q[op_rd_ptr_q] : 8'd0;
    assign rd_data   = (res_cnt_q != 3'd0) ? res_mem_q[res_rd_ptr_q] : 16'd0;
    assign op_full   = (op_cnt_q == 3'd4);
    assign res_empty = (res_cnt_q == 3'd0);
    assign err       = err_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: doc/job_dispatcher.md
JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
REQ-003 SHALL expose: wr_en  input  1  host operand push request.
REQ-004 SHALL expose: wr_data  input  8  operand value to queue.
REQ-005 SHALL expose: rd_en  input  1  host result pop request.
REQ-006 SHALL expose: done  input  1  compute-unit status; 1 = idle/ready, 0 = busy.
REQ-007 SHALL expose: res_in  input  16  compute-unit result, valid when done returns to 1.
REQ-008 SHALL expose: start  output  1  compute-unit launch strobe.
REQ-009 SHALL expose: x_out  output  8  operand presented to compute unit.
REQ-010 SHALL expose: rd_data  output  16  head of result queue.
REQ-011 SHALL expose: op_full, res_empty  output  1 each  queue status flags.
REQ-012 SHALL expose: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL expose: err  output  1  sticky timeout flag.
REQ-014 SHALL expose: wr_drop  output  1  one-cycle pulse when a push is rejected.

Function
REQ-015 SHALL hold a 4-entry operand FIFO (8 b) and a 4-entry result FIFO (16 b), each with 3-bit count and 2-bit wrapping pointers.
REQ-016 SHALL accept wr_en only when operand count < 4 (pre-edge count); else assert wr_drop next cycle, data discarded.
REQ-017 SHALL pop result FIFO on rd_en when res count > 0; rd_en on empty ignored; rd_data = head, 0 when empty.
REQ-018 SHALL allow same-cycle push and pop on either FIFO; count unchanged, both operations take effect.
REQ-019 SHALL implement a Moore FSM with states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: go to ISSUE when operand count > 0 AND res count < 4 AND done = 1; else stay.
REQ-021 ISSUE: start = 1 for exactly this one cycle; x_out = operand head; always go to WAIT_BUSY.
REQ-022 WAIT_BUSY: start = 0; done = 0 -> WAIT_DONE; 4 consecutive cycles with done = 1 -> set err, pop operand, go to IDLE.
REQ-023 WAIT_DONE: done = 1 -> write res_in to result FIFO, pop operand, go to IDLE, all on the same edge.
REQ-024 WAIT_DONE: 255 consecutive cycles with done = 0 -> set err, pop operand, no result written, go to IDLE.
REQ-025 SHALL use an 8-bit timeout counter, cleared on every state entry, saturating at 255.
REQ-026 x_out SHALL hold the operand head from ISSUE until the operand is popped.
REQ-027 Minimum job latency SHALL be 4 cycles, IDLE to IDLE, when done falls 1 cycle after start.
REQ-028 A host push during WAIT_DONE SHALL not disturb the operand at the FIFO head.
REQ-029 err SHALL be cleared only by reset; the FSM continues dispatching after an error.

Reset
REQ-030 On rst = 0 the block SHALL asynchronously enter IDLE, clear both FIFOs, counts, pointers and timer, and drive start = 0, x_out = 0, rd_data = 0, op_full = 0, res_empty = 1, busy = 0, err = 0, wr_drop = 0.
REQ-031 Reset asserted mid-job SHALL abandon the job with no result written; start SHALL not be reasserted until a new operand is pushed after reset release.

Verification
REQ-032 Push 0x05; done drops 1 cycle after start and rises 3 cycles later with res_in = 0x0123 -> exactly one start pulse with x_out = 0x05; rd_data = 0x0123; res_empty = 0.
REQ-033 Push 5 operands back-to-back while done = 1 -> op_full = 1 after the 4th push; wr_drop pulses on the 5th push; exactly 4 jobs dispatched, in order.
REQ-034 Push 0x11 with done held at 1 -> err = 1 after 4 WAIT_BUSY cycles; operand dropped; FSM returns to IDLE.
REQ-035 Hold done = 0 for 300 cycles after the busy phase -> err set at the 255th cycle; no result written; next queued job dispatches.
REQ-036 Fill the result FIFO (4 results, no rd_en), with 1 operand still queued -> no start pulse; one rd_en -> start pulse within 2 cycles.
REQ-037 Assert rst = 0 during WAIT_DONE -> outputs return to reset values immediately; after release, no start pulse without a new push.
